// File: rtl/fsub_seq_if.sv
// fsub_seq_if: operand/result handshake bundle for fsub_seq.
// The flags signal exists only when FSUB_FLAGS_EN is defined.
interface fsub_seq_if;
  // Handshake: a transfer happens on a rising clk edge where valid && ready are
  // both high; the consumer of y may keep out_ready low and y stays unchanged.
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [2:0]  state;
`ifdef FSUB_FLAGS_EN
  logic [2:0]  flags;
`endif

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, state
`ifdef FSUB_FLAGS_EN
    , output flags
`endif
  );

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, state
`ifdef FSUB_FLAGS_EN
    , input flags
`endif
  );
endinterface

// File: rtl/fsub_seq.sv
// fsub_seq: multi-cycle binary32 subtractor y = x1 - x2, round-to-nearest-even, subnormals flushed.
// Define FSUB_FLAGS_EN to add the {overflow, zero, inexact} flags output.
module fsub_seq (
  input  logic      clk,
  input  logic      rstn,
  fsub_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_OUT   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] x1_q, x1_d, x2_q, x2_d, y_q, y_d;
  logic        sign_q, sign_d, sub_q, sub_d;
  logic [8:0]  exp_q, exp_d;
  logic [27:0] ma_q, ma_d;
  logic [26:0] mb_q, mb_d;
`ifdef FSUB_FLAGS_EN
  logic [2:0]  flags_q, flags_d;
`endif

  logic        s1, s2, nan_any, inf1, inf2, special;
  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  assign {s1, e1, m1} = bus.x1;
  assign {s2, e2, m2} = bus.x2;
  assign nan_any = ((e1 == 8'hff) && (m1 != '0)) || ((e2 == 8'hff) && (m2 != '0));
  assign inf1    = (e1 == 8'hff) && (m1 == '0);
  assign inf2    = (e2 == 8'hff) && (m2 == '0);
  assign special = nan_any || inf1 || inf2 || ((e1 == '0) && (e2 == '0));

  // Significands carry 3 extra low bits: guard, round, sticky.
  logic [7:0]  ca_e, cb_e, big_e, sml_e, diff;
  logic [23:0] ca_sig, cb_sig, big_sig, sml_sig;
  logic        x1_big, big_s;
  logic [53:0] wide;
  logic [26:0] aligned;
  always_comb begin
    ca_e    = x1_q[30:23];
    cb_e    = x2_q[30:23];
    ca_sig  = (ca_e == '0) ? 24'd0 : {1'b1, x1_q[22:0]};
    cb_sig  = (cb_e == '0) ? 24'd0 : {1'b1, x2_q[22:0]};
    x1_big  = x1_q[30:0] >= x2_q[30:0];
    big_e   = x1_big ? ca_e : cb_e;
    sml_e   = x1_big ? cb_e : ca_e;
    big_sig = x1_big ? ca_sig : cb_sig;
    sml_sig = x1_big ? cb_sig : ca_sig;
    big_s   = x1_big ? x1_q[31] : ~x2_q[31];
    diff    = big_e - sml_e;
    wide    = {sml_sig, 3'b000, 27'd0} >> diff[4:0];
    if (diff >= 8'd26) aligned = {26'd0, |sml_sig};
    else               aligned = {wide[53:28], wide[27] | (|wide[26:0])};
  end

  logic [27:0] sum, sum_n;
  logic [8:0]  add_exp, r_exp;
  logic        g, r, s, rup;
  logic [24:0] rsum;
  logic [22:0] r_man;
  always_comb begin
    sum = sub_q ? (ma_q - {1'b0, mb_q}) : (ma_q + {1'b0, mb_q});
    if (sum[27]) begin
      sum_n   = {1'b0, sum[27:2], sum[1] | sum[0]};
      add_exp = exp_q + 9'd1;
    end else begin
      sum_n   = sum;
      add_exp = exp_q;
    end
    {g, r, s} = ma_q[2:0];
    rup   = g & (r | s | ma_q[3]);
    rsum  = {1'b0, ma_q[26:3]} + {24'd0, rup};
    r_exp = exp_q + {8'd0, rsum[24]};
    r_man = rsum[24] ? rsum[23:1] : rsum[22:0];
  end

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y_d     = y_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
`ifdef FSUB_FLAGS_EN
    flags_d = flags_q;
`endif
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        x1_d = bus.x1;
        x2_d = bus.x2;
        if (special) begin
          state_d = S_OUT;
`ifdef FSUB_FLAGS_EN
          flags_d = 3'b000;
`endif
          if (nan_any || (inf1 && inf2 && (s1 == s2))) y_d = 32'h7fc00000;
          else if (inf1)                               y_d = bus.x1;
          else if (inf2)                               y_d = {~s2, 8'hff, 23'd0};
          else begin
            y_d = {s1 & ~s2, 31'd0};
`ifdef FSUB_FLAGS_EN
            flags_d = 3'b010;
`endif
          end
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_d  = big_s;
        sub_d   = x1_q[31] == x2_q[31];
        exp_d   = {1'b0, big_e};
        ma_d    = {1'b0, big_sig, 3'b000};
        mb_d    = aligned;
        state_d = S_ADD;
      end
      S_ADD: begin
        ma_d    = sum_n;
        exp_d   = add_exp;
        state_d = (sum_n[26] || (sum_n == '0) || (add_exp <= 9'd1)) ? S_ROUND : S_NORM;
      end
      S_NORM: begin
        ma_d    = {ma_q[26:0], 1'b0};
        exp_d   = exp_q - 9'd1;
        state_d = (ma_q[25] || (exp_q - 9'd1 <= 9'd1)) ? S_ROUND : S_NORM;
      end
      S_ROUND: begin
        state_d = S_OUT;
        // A leading zero left at exponent 1 means the true result is below the normal range.
        if (ma_q[26:0] == '0) begin
          y_d = 32'd0;
`ifdef FSUB_FLAGS_EN
          flags_d = 3'b010;
`endif
        end else if (!ma_q[26]) begin
          y_d = {sign_q, 31'd0};
`ifdef FSUB_FLAGS_EN
          flags_d = 3'b011;
`endif
        end else if (r_exp >= 9'd255) begin
          y_d = {sign_q, 8'hff, 23'd0};
`ifdef FSUB_FLAGS_EN
          flags_d = 3'b101;
`endif
        end else begin
          y_d = {sign_q, r_exp[7:0], r_man};
`ifdef FSUB_FLAGS_EN
          flags_d = {2'b00, g | r | s};
`endif
        end
      end
      S_OUT: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      x1_q    <= '0;
      x2_q    <= '0;
      y_q     <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
`ifdef FSUB_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
`ifdef FSUB_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.y         = y_q;
  assign bus.state     = state_q;
`ifdef FSUB_FLAGS_EN
  assign bus.flags     = flags_q;
`endif
endmodule

// File: tb/tb_fsub_seq.sv
// tb_fsub_seq: directed and randomized checks of fsub_seq against an exact-integer reference model.
module tb_fsub_seq;
  localparam int W = 32;

  logic clk;
  logic rstn;
  fsub_seq_if bus ();
  fsub_seq dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   expf_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Exact difference as integers in units of 2^-149, then rounded to nearest-even.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                          output logic [2:0] fl);
    logic sa, sb, nb, sr;
    logic [7:0] ea, eb;
    logic [22:0] ma, mb;
    logic [299:0] va, vb, mag, rem, half;
    logic [24:0] man;
    int p, sh, e;
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    fl = 3'b000;
    if ((ea == 8'hff && ma != 0) || (eb == 8'hff && mb != 0)) return 32'h7fc00000;
    if (ea == 8'hff && eb == 8'hff) return (sa == sb) ? 32'h7fc00000 : a;
    if (ea == 8'hff) return a;
    if (eb == 8'hff) return {~sb, 8'hff, 23'd0};
    if (ea == 0 && eb == 0) begin
      fl = 3'b010;
      return {sa & ~sb, 31'd0};
    end
    va = (ea == 0) ? 300'd0 : (300'({1'b1, ma}) << (ea - 1));
    vb = (eb == 0) ? 300'd0 : (300'({1'b1, mb}) << (eb - 1));
    nb = ~sb;
    if (sa == nb)      begin mag = va + vb; sr = sa; end
    else if (va >= vb) begin mag = va - vb; sr = sa; end
    else               begin mag = vb - va; sr = nb; end
    if (mag == 0) begin
      fl = 3'b010;
      return 32'd0;
    end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) begin
      fl = 3'b011;
      return {sr, 31'd0};
    end
    sh   = p - 23;
    man  = 25'(mag >> sh);
    rem  = mag & ((300'd1 << sh) - 300'd1);
    half = (sh == 0) ? 300'd0 : (300'd1 << (sh - 1));
    if (rem > half || (sh > 0 && rem == half && man[0])) man = man + 25'd1;
    e = p - 22;
    if (man[24]) begin
      man = man >> 1;
      e++;
    end
    if (e >= 255) begin
      fl = 3'b101;
      return {sr, 8'hff, 23'd0};
    end
    fl = {2'b00, rem != 0};
    return {sr, e[7:0], man[22:0]};
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hff) || (b[30:23] == 8'hff) || (a[30:23] == 0 && b[30:23] == 0);
  endfunction

  // One full transaction: issue, measure latency, check result, stall, release.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                    input int hold, input string tag);
    logic [31:0] ey, yv;
    logic [2:0]  ef;
    int lat;
    ey = ref_sub(a, b, ef);
    exp_q.push_back(ey);
    expf_q.push_back(ef);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.x1 = a;
    bus.x2 = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    bus.in_valid = 1'b0;
    bus.x1 = $urandom();
    bus.x2 = $urandom();
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    else             check({tag, "_latency_le31"}, 32'(lat <= 31), 32'd1);
    @(negedge clk);
    yv = bus.y;
    check({tag, "_y"}, yv, exp_q.pop_front());
`ifdef FSUB_FLAGS_EN
    check({tag, "_flags"}, 32'(bus.flags), 32'(expf_q.pop_front()));
`else
    void'(expf_q.pop_front());
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.x1 = $urandom();
      bus.x2 = $urandom();
      @(negedge clk);
      check({tag, "_hold_y"}, bus.y, yv);
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int k, lat_exp;
    bit seen;
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1 = '0;
    bus.x2 = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", bus.y, 32'd0);
`ifdef FSUB_FLAGS_EN
    check("rst_flags", 32'(bus.flags), 32'd0);
`endif
    rstn = 1'b1;

    op(32'h40400000, 32'h40400000, 4, 0, "equal_cancel");
    op(32'h4048f5c3, 32'h40000000, 5, 0, "one_shift");
    op(32'h3f800000, 32'h3f8ccccd, 8, 0, "four_shifts");
    op(32'h7f800000, 32'h7f800000, 1, 0, "inf_minus_inf");
    op(32'h7f7fffff, 32'hff7fffff, 4, 0, "overflow");
    op(32'h80000000, 32'h00000000, 1, 0, "neg0_minus_pos0");
    op(32'h00000000, 32'h00000000, 1, 0, "pos0_minus_pos0");
    op(32'h80000005, 32'h00000000, 1, 0, "subnorm_flush");
    op(32'h3f800000, 32'hff800000, 1, 0, "x2_inf");
    op(32'h7fc00001, 32'h3f800000, 1, 0, "nan_in");
    op(32'h00800000, 32'h00800001, 4, 0, "underflow_flush");
    op(32'h00000000, 32'h40400000, 4, 0, "zero_minus_x");
    op(32'h4b800000, 32'h3f800000, -1, 0, "far_align");
    op(32'h41200000, 32'hc0a00000, 4, 10, "stall_out");

    for (int n = 0; n < 200; n++) begin
      a = $urandom();
      b = $urandom();
      k = $urandom_range(0, 7);
      if (k < 3) begin
        b[31] = a[31];
        b[30:23] = a[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
      end else if (k == 3) begin
        b[31] = a[31];
        b[30:23] = a[30:23];
        b[22:0] = a[22:0] ^ 23'(1 << $urandom_range(0, 22));
      end else if (k == 4) begin
        a[30:23] = ($urandom_range(0, 1) == 1) ? 8'hff : 8'h00;
        if ($urandom_range(0, 1) == 1) a[22:0] = '0;
        if ($urandom_range(0, 1) == 1) b[30:23] = a[30:23];
      end else if (k == 5) begin
        a[30:23] = 8'hfe;
        b[30:23] = 8'hfe - 8'($urandom_range(0, 3));
      end
      if (is_special(a, b))                                          lat_exp = 1;
      else if (a[31] != b[31] || a[30:23] == 0 || b[30:23] == 0)    lat_exp = 4;
      else                                                           lat_exp = -1;
      op(a, b, lat_exp, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    bus.x1 = 32'h3f800000;
    bus.x2 = 32'h3f8ccccd;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #2;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_y", bus.y, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsub_seq.md
FSUB_SEQ -- requirements
Module: fsub_seq

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32 bits (IEEE-754 binary32).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair x1/x2 valid.
REQ-005 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-006 x1  input  32  minuend, binary32.
REQ-007 x2  input  32  subtrahend, binary32.
REQ-008 out_valid  output  1  y holds a completed result.
REQ-009 out_ready  input  1  consumer takes y.
REQ-010 y  output  32  x1 - x2, binary32, held stable while out_valid high.
REQ-011 flags  output  3  {overflow, zero, inexact}; present only under FSUB_FLAGS_EN.

Function
REQ-012 SHALL compute y = x1 - x2 with round-to-nearest-even.
REQ-013 SHALL capture x1/x2 on the cycle in_valid && in_ready; operands are ignored at all other times.
REQ-014 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, ROUND, OUT.
REQ-015 IDLE->ALIGN on accept; IDLE->OUT on accept when a special case (REQ-021..023) applies.
REQ-016 ALIGN (1 cycle): flip x2 sign, swap so larger magnitude first, right-shift smaller significand by exponent difference, keep guard/round/sticky; difference >= 26 collapses to sticky only.
REQ-017 ADD (1 cycle): 25-bit add/subtract of significands; on carry-out, right-shift 1, exponent+1, fold shifted bit into sticky.
REQ-018 NORM: left-shift one bit per cycle, decrementing exponent, until bit 23 set or exponent reaches 1; zero significand goes straight to ROUND.
REQ-019 ROUND (1 cycle): apply RNE from guard/round/sticky; mantissa carry renormalises with exponent+1.
REQ-020 Latency accept->out_valid: 4 cycles + NORM shift count (max 27); special cases 1 cycle.
REQ-021 Any NaN input, or inf - inf of same sign, SHALL give y = 32'h7fc00000.
REQ-022 Exactly one infinite operand SHALL give that infinity (sign of x2 inverted when x2 is infinite).
REQ-023 Subnormal inputs SHALL be flushed to signed zero; zero minus zero SHALL give -0 only for (-0) - (+0), else +0.
REQ-024 Exact-zero nonspecial results SHALL be +0; result exponent < 1 SHALL flush to signed zero.
REQ-025 Result exponent >= 255 after rounding SHALL give signed infinity.
REQ-026 OUT: out_valid=1; OUT->IDLE on out_ready; y and flags held unchanged while out_ready low.
REQ-027 in_ready SHALL be 0 in every state except IDLE; no operand queueing.

Reset
REQ-028 rstn low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, y=32'h0, flags=3'b0.
REQ-029 Reset mid-operation SHALL discard the operation with no result emitted.

Configuration
REQ-030 Macro FSUB_FLAGS_EN defined: flags port exists; overflow=REQ-025 fired, zero=result is +/-0, inexact=any of guard/round/sticky set or flush occurred; valid with out_valid.
REQ-031 FSUB_FLAGS_EN undefined: flags port and its logic absent; y and timing identical.

Verification
REQ-032 x1=32'h40400000, x2=32'h40400000 -> y=32'h00000000, flags=3'b010.
REQ-033 x1=32'h4048f5c3, x2=32'h40000000 -> y=32'h3f91eb86, latency 5 cycles (1 NORM shift).
REQ-034 x1=32'h3f800000, x2=32'h3f8ccccd -> y=32'hbdccccd0 after 4 NORM shifts, latency 8.
REQ-035 x1=32'h7f800000, x2=32'h7f800000 -> y=32'h7fc00000 after 1 cycle; x1=32'h7f7fffff, x2=32'hff7fffff -> y=32'h7f800000, flags=3'b101.
REQ-036 out_ready low 10 cycles in OUT -> y stable, in_ready=0, in_valid ignored; rstn pulse during NORM -> out_valid never asserts, in_ready=1 after release.
